alu32_reg: RTL and testbench

//  Registered 32-bit MIPS-style ALU for the datapath execute stage.

---
 rtl/alu32_reg.sv | 138 +++++++++++++
 tb/tb_alu32_reg.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu32_reg.sv
// alu32_reg: registered 32-bit MIPS-style ALU for the datapath execute stage.
//
// One of eight operations, selected by ALUControlBit, is applied to the two
// operands. The result and its status flags are captured on the rising clock
// edge, so downstream logic sees them one cycle after the inputs were sampled.
//
// Ports:
//   clk            in   1       single clock, rising-edge
//   rst_n          in   1       synchronous active-low reset
//   content1       in   DATA_W  operand A (rs)
//   content2       in   DATA_W  operand B (rt/imm); low bits are the shift amount
//   ALUControlBit  in   3       operation select
//   ALUresult      out  DATA_W  registered result
//   zero           out  1       registered, 1 when ALUresult == 0
//   overflow       out  1       registered signed overflow (ADD/SUB only)
//   carryOut       out  1       registered carry out of the MSB (ADD/SUB only)
//
// Opcodes: 000 AND, 001 OR, 010 ADD, 011 XOR (or SRA), 100 SLL, 101 SRL,
//          110 SUB, 111 SLT (signed).
//
// Build option: define ALU_SRA_EN to turn opcode 011 into an arithmetic right
// shift of A by the shift amount; left undefined, opcode 011 is A ^ B.

module alu32_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] content1,
  input  logic [DATA_W-1:0] content2,
  input  logic [2:0]        ALUControlBit,
  output logic [DATA_W-1:0] ALUresult,
  output logic              zero,
  output logic              overflow,
  output logic              carryOut
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  // Signed less-than straight from the operands, so the answer stays right
  // even when A - B would overflow.
  function automatic logic slt_fn(input logic signed [DATA_W-1:0] a,
                                  input logic signed [DATA_W-1:0] b);
    return a < b;
  endfunction

  // Signed overflow of a + b_eff: operand signs agree, result sign differs.
  function automatic logic ovf_fn(input logic a_msb, input logic b_msb,
                                  input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // ---- stage p0: combinational operation ----
  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic [SH_W-1:0]          shamt_p0;
  logic                     is_sub_p0;
  logic [DATA_W-1:0]        b_eff_p0;
  logic [DATA_W:0]          sum_p0;
  logic                     add_ovf_p0;
  op_t                      op_p0;

  logic [DATA_W-1:0]        result_p0;
  logic                     ovf_p0;
  logic                     carry_p0;

  assign a_p0      = content1;
  assign b_p0      = content2;
  assign op_p0     = op_t'(ALUControlBit);
  assign shamt_p0  = content2[SH_W-1:0];
  assign is_sub_p0 = (op_p0 == OP_SUB);

  // SUB shares the adder as A + ~B + 1; the carry-in supplies the +1.
  assign b_eff_p0   = is_sub_p0 ? ~b_p0 : b_p0;
  assign sum_p0     = {1'b0, a_p0} + {1'b0, b_eff_p0} + {{DATA_W{1'b0}}, is_sub_p0};
  assign add_ovf_p0 = ovf_fn(a_p0[DATA_W-1], b_eff_p0[DATA_W-1], sum_p0[DATA_W-1]);

  always_comb begin
    result_p0 = '0;
    ovf_p0    = 1'b0;
    carry_p0  = 1'b0;
    unique case (op_p0)
      OP_AND: result_p0 = a_p0 & b_p0;
      OP_OR:  result_p0 = a_p0 | b_p0;
      OP_ADD, OP_SUB: begin
        result_p0 = sum_p0[DATA_W-1:0];
        ovf_p0    = add_ovf_p0;
        carry_p0  = sum_p0[DATA_W];
      end
`ifdef ALU_SRA_EN
      OP_XOR: result_p0 = a_p0 >>> shamt_p0;
`else
      OP_XOR: result_p0 = a_p0 ^ b_p0;
`endif
      OP_SLL: result_p0 = a_p0 << shamt_p0;
      OP_SRL: result_p0 = content1 >> shamt_p0;
      OP_SLT: result_p0 = {{(DATA_W-1){1'b0}}, slt_fn(a_p0, b_p0)};
      default: result_p0 = '0;
    endcase
  end

  // ---- stage p1: output registers ----
  logic [DATA_W-1:0] result_p1;
  logic              zero_p1;
  logic              ovf_p1;
  logic              carry_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_p1 <= '0;
      zero_p1   <= 1'b1;
      ovf_p1    <= 1'b0;
      carry_p1  <= 1'b0;
    end else begin
      result_p1 <= result_p0;
      zero_p1   <= (result_p0 == '0);
      ovf_p1    <= ovf_p0;
      carry_p1  <= carry_p0;
    end
  end

  assign ALUresult = result_p1;
  assign zero      = zero_p1;
  assign overflow  = ovf_p1;
  assign carryOut  = carry_p1;

endmodule

// File: tb/tb_alu32_reg.sv
module tb_alu32_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] content1;
  logic [31:0] content2;
  logic [2:0]  ALUControlBit;
  logic [31:0] ALUresult;
  logic        zero;
  logic        overflow;
  logic        carryOut;

  int n_checks = 0;
  int n_fail   = 0;

  alu32_reg #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .content1      (content1),
    .content2      (content2),
    .ALUControlBit (ALUControlBit),
    .ALUresult     (ALUresult),
    .zero          (zero),
    .overflow      (overflow),
    .carryOut      (carryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        c;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] res, input logic z,
                           input logic ov, input logic c);
    check({name, ".result"},   ALUresult, res);
    check({name, ".zero"},     {31'd0, zero}, {31'd0, z});
    check({name, ".overflow"}, {31'd0, overflow}, {31'd0, ov});
    check({name, ".carry"},    {31'd0, carryOut}, {31'd0, c});
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControlBit = op;
    content1      = a;
    content2      = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'h0000000F, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 32'h0000000F, 32'h00000005, 32'h0000000F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 32'h0000000F, 32'h00000005, 32'h00000014, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b110, 32'h00000001, 32'h00000005, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b111, 32'h00000001, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b111, 32'h0000000F, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 32'h0000000F, 32'h00000003, 32'h00000078, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 32'h0000000F, 32'h00000003, 32'h00000001, 1'b0, 1'b0, 1'b0};
`ifdef ALU_SRA_EN
    vecs[8]  = '{3'b011, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
`else
    vecs[8]  = '{3'b011, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
`endif
    vecs[9]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b111, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{3'b100, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{3'b101, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{3'b100, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{3'b000, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{3'b101, 32'hFFFFFFFF, 32'h00000004, 32'h0FFFFFFF, 1'b0, 1'b0, 1'b0};

    // Reset held for two edges with inputs that would otherwise set carry.
    rst_n = 1'b0;
    drive(3'b010, 32'hFFFFFFFF, 32'h00000001);
    tick();
    check_all("reset_edge1", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("reset_edge2", 32'h0, 1'b1, 1'b0, 1'b0);

    // Release, then one edge: outputs follow inputs.
    rst_n = 1'b1;
    drive(3'b001, 32'h0000000F, 32'h00000005);
    tick();
    check_all("post_reset_or", 32'h0000000F, 1'b0, 1'b0, 1'b0);

    // Table-driven vectors, back to back, each checked one edge later.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].ov, vecs[i].c);
    end

    // Latency: a new input must not reach the output before the edge.
    drive(3'b000, 32'h0000000F, 32'h00000005);
    tick();
    check_all("lat_and", 32'h00000005, 1'b0, 1'b0, 1'b0);
    drive(3'b010, 32'h0000000F, 32'h00000005);
    #2;
    check_all("lat_hold", 32'h00000005, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("lat_add", 32'h00000014, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream has priority over an op that would set flags.
    drive(3'b010, 32'h7FFFFFFF, 32'h00000001);
    tick();
    check_all("pre_midreset", 32'h80000000, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive(3'b010, 32'hFFFFFFFF, 32'h00000001);
    tick();
    check_all("midreset", 32'h0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("after_midreset", 32'h0, 1'b1, 1'b0, 1'b1);
    drive(3'b110, 32'h00000001, 32'h00000005);
    tick();
    check_all("after_midreset_sub", 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
